// File: rtl/alu_issue_ctrl_if.sv
// Command and result handshake bundle for the alu issue stage.
// master = producer/consumer side, slave = the issue controller.
interface alu_issue_ctrl_if #(
  parameter int OP_W  = 32,
  parameter int RES_W = 16
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [OP_W-1:0]  cmd_a;
  logic [OP_W-1:0]  cmd_b;
  logic [1:0]       cmd_sel;
  logic             res_valid;
  logic             res_ready;
  logic [RES_W-1:0] res_data;
  logic             res_cout;
  logic [1:0]       res_sel;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, res_ready,
    input  cmd_ready, res_valid, res_data, res_cout, res_sel
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, res_ready,
    output cmd_ready, res_valid, res_data, res_cout, res_sel
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Command-issue / result-capture stage around a combinational alu.
// Commands are buffered in a small FIFO, issued one at a time from
// registered operands, sampled after one settle cycle and held for the
// downstream consumer until accepted.
module alu_issue_ctrl #(
  parameter int DEPTH = 4,
  parameter int OP_W  = 32,
  parameter int RES_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_issue_ctrl_if.slave          bus,
  output logic [OP_W-1:0]          alu_a,
  output logic [OP_W-1:0]          alu_b,
  output logic [1:0]               alu_sel,
  input  logic [RES_W-1:0]         alu_out,
  input  logic                     alu_cout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 * OP_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [EW-1:0]    mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt_s;
  logic             cmd_ready_r;
  logic             busy_r;
  logic             res_valid_r;
  logic             res_cout_r;
  logic [RES_W-1:0] res_data_r;
  logic [1:0]       res_sel_r;
  logic [OP_W-1:0]  alu_a_r;
  logic [OP_W-1:0]  alu_b_r;
  logic [1:0]       alu_sel_r;
  logic             push_s;
  logic             pop_s;
  logic             fifo_nempty_s;
  logic             res_hs_s;
  logic [EW-1:0]    head_s;

  assign head_s        = mem_r[rd_ptr_r];
  assign bus.cmd_ready = cmd_ready_r;
  assign bus.res_valid = res_valid_r;
  assign bus.res_data  = res_data_r;
  assign bus.res_cout  = res_cout_r;
  assign bus.res_sel   = res_sel_r;
  assign alu_a         = alu_a_r;
  assign alu_b         = alu_b_r;
  assign alu_sel       = alu_sel_r;
  assign count         = count_r;
  assign busy          = busy_r;

  // Handshake qualifiers, pop decision, next state and next occupancy.
  always_comb begin
    fifo_nempty_s = (count_r != {CW{1'b0}});
    push_s        = bus.cmd_valid && cmd_ready_r;
    res_hs_s      = res_valid_r && bus.res_ready;
    pop_s         = 1'b0;
    state_nxt_s   = state_r;
    case (state_r)
      ST_IDLE: begin
        if (fifo_nempty_s) begin
          pop_s       = 1'b1;
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_nxt_s = ST_HOLD;
      end
      ST_HOLD: begin
        if (res_hs_s) begin
          if (fifo_nempty_s) begin
            pop_s       = 1'b1;
            state_nxt_s = ST_ISSUE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        pop_s       = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
    count_nxt_s = count_r + CW'(push_s) - CW'(pop_s);
  end

  // FIFO storage: write the accepted command at the tail.
  always_ff @(posedge clk) begin
    if (rst_n && push_s) begin
      mem_r[wr_ptr_r] <= {bus.cmd_a, bus.cmd_b, bus.cmd_sel};
    end
  end

  // Issue FSM, FIFO pointers/occupancy and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      cmd_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      alu_a_r     <= {OP_W{1'b0}};
      alu_b_r     <= {OP_W{1'b0}};
      alu_sel_r   <= 2'd0;
      res_valid_r <= 1'b0;
      res_data_r  <= {RES_W{1'b0}};
      res_cout_r  <= 1'b0;
      res_sel_r   <= 2'd0;
    end else begin
      state_r     <= state_nxt_s;
      count_r     <= count_nxt_s;
      cmd_ready_r <= (count_nxt_s < CW'(DEPTH));
      busy_r      <= (state_nxt_s != ST_IDLE) || (count_nxt_s != {CW{1'b0}});
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      // Operands only move on a pop edge, so they are stable through ISSUE.
      if (pop_s) begin
        rd_ptr_r                       <= rd_ptr_r + AW'(1);
        {alu_a_r, alu_b_r, alu_sel_r}  <= head_s;
      end
      case (state_r)
        ST_ISSUE: begin
          res_data_r  <= alu_out;
          res_cout_r  <= alu_cout;
          res_sel_r   <= alu_sel_r;
          res_valid_r <= 1'b1;
        end
        ST_HOLD: begin
          if (res_hs_s) begin
            res_valid_r <= 1'b0;
          end
        end
        default: begin
          res_valid_r <= res_valid_r;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a 16-bit adder standing in for the alu.
module tb_alu_issue_ctrl;
  localparam int DEPTH = 4;
  localparam int OP_W  = 32;
  localparam int RES_W = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_a, alu_b;
  logic [1:0]  alu_sel;
  logic [15:0] alu_out;
  logic        alu_cout;
  logic [2:0]  count;
  logic        busy;

  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.OP_W(OP_W), .RES_W(RES_W)) bus ();

  alu_issue_ctrl #(.DEPTH(DEPTH), .OP_W(OP_W), .RES_W(RES_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_cout(alu_cout),
    .count(count), .busy(busy)
  );

  assign {alu_cout, alu_out} = {1'b0, alu_a[15:0]} + {1'b0, alu_b[15:0]};

  typedef struct packed {
    logic [15:0] d;
    logic        c;
    logic [1:0]  s;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  s;
    logic [15:0] d;
    logic        c;
  } vec_t;

  res_t exp_q[$];
  vec_t vecs[6];
  int   checks   = 0;
  int   failures = 0;
  int   sent, got, last;
  logic acc;
  res_t e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s);
    logic [16:0] sum;
    res_t r;
    sum = {1'b0, a[15:0]} + {1'b0, b[15:0]};
    r.d = sum[15:0];
    r.c = sum[16];
    r.s = s;
    return r;
  endfunction

  task automatic push_cmd(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s, input res_t ex);
    int k;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_sel   = s;
    bus.cmd_valid = 1'b1;
    k = 0;
    while (!bus.cmd_ready && k < 20) begin
      step();
      k++;
    end
    chk("push_ready", 32'(bus.cmd_ready), 32'd1);
    exp_q.push_back(ex);
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic take_result(input string name);
    int   k;
    res_t ex;
    bus.res_ready = 1'b1;
    k = 0;
    while (!bus.res_valid && k < 20) begin
      step();
      k++;
    end
    chk({name, "_valid"}, 32'(bus.res_valid), 32'd1);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_order actual=extra_result expected=none", name);
    end else begin
      ex = exp_q.pop_front();
      chk({name, "_data"}, 32'(bus.res_data), 32'(ex.d));
      chk({name, "_cout"}, 32'(bus.res_cout), 32'(ex.c));
      chk({name, "_sel"},  32'(bus.res_sel),  32'(ex.s));
    end
    step();
  endtask

  task automatic set_stream(input int n);
    bus.cmd_a   = 32'(n * 256 + 7);
    bus.cmd_b   = 32'(n);
    bus.cmd_sel = 2'(n);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0002, 32'h0000_0001, 2'd0, 16'h0003, 1'b0};
    vecs[1] = '{32'h0000_FFFF, 32'h0000_0001, 2'd2, 16'h0000, 1'b1};
    vecs[2] = '{32'h0000_8000, 32'h0000_8000, 2'd1, 16'h0000, 1'b1};
    vecs[3] = '{32'h0000_1234, 32'h0000_4321, 2'd3, 16'h5555, 1'b0};
    vecs[4] = '{32'hABCD_0001, 32'h1234_0002, 2'd0, 16'h0003, 1'b0};
    vecs[5] = '{32'h0000_FFFF, 32'h0000_FFFF, 2'd1, 16'hFFFE, 1'b1};

    bus.cmd_valid = 1'b0;
    bus.cmd_a     = 32'd0;
    bus.cmd_b     = 32'd0;
    bus.cmd_sel   = 2'd0;
    bus.res_ready = 1'b0;
    rst_n         = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_count",     32'(count),         32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_busy",      32'(busy),          32'd0);
    chk("rst_alu_a",     alu_a,              32'd0);
    chk("rst_res_data",  32'(bus.res_data),  32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_cmd_ready_after", 32'(bus.cmd_ready), 32'd1);

    // Single command latency: accept E0, pop E1, capture E2
    bus.cmd_a     = 32'd2;
    bus.cmd_b     = 32'd1;
    bus.cmd_sel   = 2'd0;
    bus.cmd_valid = 1'b1;
    bus.res_ready = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    chk("t1_count_e0", 32'(count),         32'd1);
    chk("t1_valid_e0", 32'(bus.res_valid), 32'd0);
    step();
    chk("t1_alu_a_e1", alu_a,              32'd2);
    chk("t1_count_e1", 32'(count),         32'd0);
    chk("t1_valid_e1", 32'(bus.res_valid), 32'd0);
    chk("t1_busy_e1",  32'(busy),          32'd1);
    step();
    chk("t1_valid_e2", 32'(bus.res_valid), 32'd1);
    chk("t1_data_e2",  32'(bus.res_data),  32'h0003);
    chk("t1_cout_e2",  32'(bus.res_cout),  32'd0);
    chk("t1_sel_e2",   32'(bus.res_sel),   32'd0);
    step();
    chk("t1_valid_hs", 32'(bus.res_valid), 32'd0);
    chk("t1_busy_hs",  32'(busy),          32'd0);

    // Table-driven single commands
    for (int i = 0; i < 6; i++) begin
      e.d = vecs[i].d;
      e.c = vecs[i].c;
      e.s = vecs[i].s;
      push_cmd(vecs[i].a, vecs[i].b, vecs[i].s, e);
      step();
      chk("vec_alu_a",   alu_a,          vecs[i].a);
      chk("vec_alu_b",   alu_b,          vecs[i].b);
      chk("vec_alu_sel", 32'(alu_sel),   32'(vecs[i].s));
      take_result("vec");
    end

    // Backpressure: five commands with res_ready low
    bus.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_cmd(32'(16 * (i + 1)), 32'(i), 2'(i), model(32'(16 * (i + 1)), 32'(i), 2'(i)));
    end
    chk("t3_count_full", 32'(count),         32'd4);
    chk("t3_ready_full", 32'(bus.cmd_ready), 32'd0);
    step();
    step();
    step();
    chk("t3_hold_valid", 32'(bus.res_valid), 32'd1);
    chk("t3_hold_data",  32'(bus.res_data),  32'h0010);
    chk("t3_hold_sel",   32'(bus.res_sel),   32'd0);
    chk("t3_hold_count", 32'(count),         32'd4);
    for (int i = 0; i < 5; i++) take_result("t3");

    // Full FIFO: blocked push and result handshake in the same cycle
    bus.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_cmd(32'(32'h40 + i), 32'h0000_0100, 2'(3 - i), model(32'(32'h40 + i), 32'h0000_0100, 2'(3 - i)));
    end
    chk("t4_valid", 32'(bus.res_valid), 32'd1);
    chk("t4_ready", 32'(bus.cmd_ready), 32'd0);
    chk("t4_count", 32'(count),         32'd4);
    bus.cmd_a     = 32'h0000_7000;
    bus.cmd_b     = 32'h0000_0100;
    bus.cmd_sel   = 2'd3;
    bus.cmd_valid = 1'b1;
    bus.res_ready = 1'b1;
    e = exp_q.pop_front();
    chk("t4_hs_data", 32'(bus.res_data), 32'(e.d));
    chk("t4_hs_sel",  32'(bus.res_sel),  32'(e.s));
    step();
    chk("t4_count_after_pop", 32'(count),         32'd3);
    chk("t4_ready_after_pop", 32'(bus.cmd_ready), 32'd1);
    chk("t4_valid_after_pop", 32'(bus.res_valid), 32'd0);
    exp_q.push_back(model(32'h0000_7000, 32'h0000_0100, 2'd3));
    step();
    bus.cmd_valid = 1'b0;
    chk("t4_count_refill", 32'(count), 32'd4);
    for (int i = 0; i < 5; i++) take_result("t4");

    // Streaming with res_ready held high
    bus.res_ready = 1'b1;
    sent = 0;
    got  = 0;
    last = -1;
    set_stream(0);
    bus.cmd_valid = 1'b1;
    for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
      acc = bus.cmd_valid && bus.cmd_ready;
      if (bus.res_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL t5_order actual=extra_result expected=none");
        end else begin
          e = exp_q.pop_front();
          chk("t5_data", 32'(bus.res_data), 32'(e.d));
          chk("t5_sel",  32'(bus.res_sel),  32'(e.s));
        end
        if (last >= 0) chk("t5_gap", 32'(cyc - last), 32'd2);
        last = cyc;
        got++;
      end
      if (acc) begin
        exp_q.push_back(model(bus.cmd_a, bus.cmd_b, bus.cmd_sel));
        sent++;
      end
      step();
      if (acc) begin
        if (sent < 8) set_stream(sent);
        else bus.cmd_valid = 1'b0;
      end
    end
    chk("t5_got",  32'(got),  32'd8);
    chk("t5_sent", 32'(sent), 32'd8);
    step();
    chk("t5_busy_end", 32'(busy), 32'd0);

    // Reset while holding a result with three queued commands
    bus.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_cmd(32'(32'h500 + i), 32'h0000_0011, 2'(i), model(32'(32'h500 + i), 32'h0000_0011, 2'(i)));
    end
    chk("t6_pre_count", 32'(count),         32'd3);
    chk("t6_pre_valid", 32'(bus.res_valid), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_q.delete();
    chk("t6_valid",   32'(bus.res_valid), 32'd0);
    chk("t6_count",   32'(count),         32'd0);
    chk("t6_alu_a",   alu_a,              32'd0);
    chk("t6_alu_b",   alu_b,              32'd0);
    chk("t6_alu_sel", 32'(alu_sel),       32'd0);
    chk("t6_busy",    32'(busy),          32'd0);
    chk("t6_data",    32'(bus.res_data),  32'd0);
    push_cmd(32'h0000_00F0, 32'h0000_000F, 2'd2, model(32'h0000_00F0, 32'h0000_000F, 2'd2));
    take_result("t6_fresh");
    chk("t6_busy_end", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
